txgen: RTL and testbench

Bus response frame generator; the transmit-side counterpart of the bus receive parser. When the parser requests a reply (`ret_cmd_flg` pulse), this block latches the response code, sensor ID and 32-bit data word, then builds a 12-byte bus frame. It feeds the frame byte by byte to the UART byte transmitter under a one-byte-at-a-time handshake and appends a CRC-16/MODBUS. A one-entry pending buffer absorbs a second request that arrives mid-frame.

---
 rtl/txgen.sv | 204 ++++++++++++++++++++
 tb/tb_txgen.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/txgen.sv
// txgen: bus response frame generator.
// Builds a 12-byte reply frame (AA 55 00 08 SID CMD D3 D2 D1 D0 CRC_L CRC_H)
// and hands it to a UART byte transmitter one byte at a time. The CRC is
// CRC-16/MODBUS over SID..D0. A one-entry pending buffer holds a request that
// arrives while a frame is in flight.
// Ports:
//   sys_clk, sys_rst      clock, async active-low reset
//   ret_cmd/sid/data      reply contents, valid with ret_cmd_flg
//   ret_cmd_flg           one-cycle request strobe
//   tx_data, tx_flag      byte + strobe to the UART
//   tx_done               UART byte-complete pulse
//   busy                  frame in progress
//   frame_done            pulse after the last byte completes
//   req_ovf               pulse when a request is dropped
//   tx_err                pulse when a frame is aborted on UART timeout
module txgen #(
  parameter int unsigned TX_TIMEOUT = 100000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  ret_cmd,
  input  logic [7:0]  ret_sid,
  input  logic [31:0] ret_data,
  input  logic        ret_cmd_flg,
  output logic [7:0]  tx_data,
  output logic        tx_flag,
  input  logic        tx_done,
  output logic        busy,
  output logic        frame_done,
  output logic        req_ovf,
  output logic        tx_err
);

  localparam int unsigned TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  localparam int unsigned IW = 4;
  localparam int unsigned CW = 16;
  localparam logic [IW-1:0] LAST_IDX = IW'(11);
  localparam logic [TW-1:0] TMO_LAST = TW'(TX_TIMEOUT - 1);
  localparam logic [CW-1:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t state, next_state;

  logic [7:0]    act_cmd, act_sid, pend_cmd, pend_sid;
  logic [31:0]   act_data, pend_data;
  logic          pend_vld;
  logic [IW-1:0] idx;
  logic [TW-1:0] timer;
  logic [CW-1:0] crc;
  logic [7:0]    cur_byte_c;

  logic start_c, done_c, last_c, tmo_c, chain_c, busy_req_c;
  logic load_in_c, load_pend_c, capture_c, ovf_c, crc_cov_c;
  logic flag_d, busy_d, frame_done_d, ovf_d, err_d;

  // One full byte of CRC-16/MODBUS (reflected 0xA001).
  function automatic logic [CW-1:0] crc_step(input logic [CW-1:0] crc_in, input logic [7:0] din);
    logic [CW-1:0] c;
    c = crc_in ^ {8'h00, din};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  // Frame byte selected by the current index.
  always_comb begin
    cur_byte_c = 8'h00;
    case (idx)
      4'd0:    cur_byte_c = 8'hAA;
      4'd1:    cur_byte_c = 8'h55;
      4'd2:    cur_byte_c = 8'h00;
      4'd3:    cur_byte_c = 8'h08;
      4'd4:    cur_byte_c = act_sid;
      4'd5:    cur_byte_c = act_cmd;
      4'd6:    cur_byte_c = act_data[31:24];
      4'd7:    cur_byte_c = act_data[23:16];
      4'd8:    cur_byte_c = act_data[15:8];
      4'd9:    cur_byte_c = act_data[7:0];
      4'd10:   cur_byte_c = crc[7:0];
      4'd11:   cur_byte_c = crc[15:8];
      default: cur_byte_c = 8'h00;
    endcase
  end

  // Control decode. At the last tx_done a request arriving with the pending
  // slot empty starts the next frame directly, otherwise it would be parked in
  // pending while the FSM falls back to IDLE and never be served.
  always_comb begin
    start_c     = (state == S_IDLE) && ret_cmd_flg;
    done_c      = (state == S_WAIT) && tx_done;
    last_c      = done_c && (idx == LAST_IDX);
    tmo_c       = (state == S_WAIT) && !tx_done && (timer == TMO_LAST);
    chain_c     = last_c && (pend_vld || ret_cmd_flg);
    busy_req_c  = (state != S_IDLE) && ret_cmd_flg;
    load_pend_c = chain_c && pend_vld;
    load_in_c   = start_c || (chain_c && !pend_vld);
    capture_c   = busy_req_c && !tmo_c && (last_c ? pend_vld : !pend_vld);
    ovf_c       = busy_req_c && (tmo_c || (!last_c && pend_vld));
    crc_cov_c   = (idx >= IW'(4)) && (idx <= IW'(9));
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state logic; tx_done beats a coincident timeout.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (ret_cmd_flg) next_state = S_SEND;
      S_SEND: next_state = S_WAIT;
      S_WAIT: begin
        if (done_c) begin
          if (!last_c || chain_c) next_state = S_SEND;
          else                    next_state = S_IDLE;
        end else if (tmo_c) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode, registered below.
  always_comb begin
    flag_d       = (state == S_SEND);
    busy_d       = (next_state != S_IDLE);
    frame_done_d = last_c;
    ovf_d        = ovf_c;
    err_d        = tmo_c;
  end

  // Output registers.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      tx_data    <= 8'h00;
      tx_flag    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      req_ovf    <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      tx_flag    <= flag_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      req_ovf    <= ovf_d;
      tx_err     <= err_d;
      if (flag_d) tx_data <= cur_byte_c;
    end
  end

  // Active frame registers, byte index, timeout counter and CRC.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      act_cmd  <= 8'h00;
      act_sid  <= 8'h00;
      act_data <= 32'h0;
      idx      <= '0;
      timer    <= '0;
      crc      <= CRC_INIT;
    end else begin
      if (load_in_c) begin
        act_cmd  <= ret_cmd;
        act_sid  <= ret_sid;
        act_data <= ret_data;
      end else if (load_pend_c) begin
        act_cmd  <= pend_cmd;
        act_sid  <= pend_sid;
        act_data <= pend_data;
      end

      if (load_in_c || load_pend_c)  idx <= '0;
      else if (done_c && !last_c)    idx <= idx + IW'(1);

      if (state == S_SEND)      timer <= '0;
      else if (state == S_WAIT) timer <= timer + TW'(1);

      if (load_in_c || load_pend_c)          crc <= CRC_INIT;
      else if (state == S_SEND && crc_cov_c) crc <= crc_step(crc, cur_byte_c);
    end
  end

  // One-entry pending buffer.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      pend_vld  <= 1'b0;
      pend_cmd  <= 8'h00;
      pend_sid  <= 8'h00;
      pend_data <= 32'h0;
    end else if (capture_c) begin
      pend_vld  <= 1'b1;
      pend_cmd  <= ret_cmd;
      pend_sid  <= ret_sid;
      pend_data <= ret_data;
    end else if (tmo_c || load_pend_c) begin
      pend_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_txgen.sv
// tb_txgen: self-checking bench for txgen. A UART model answers each tx_flag
// with tx_done after a programmable delay; a reference model predicts frame
// contents, start cycles, frame_done timing and dropped requests.
module tb_txgen;

  localparam int TO = 50;

  logic        sys_clk, sys_rst;
  logic [7:0]  ret_cmd, ret_sid, tx_data;
  logic [31:0] ret_data;
  logic        ret_cmd_flg, tx_flag, tx_done, busy, frame_done, req_ovf, tx_err;
  logic        uart_done, spur;

  typedef struct {int t; logic [7:0] sid; logic [7:0] cmd; logic [31:0] data;} req_t;
  typedef struct {int f0; logic [7:0] sid; logic [7:0] cmd; logic [31:0] data;} frm_t;

  req_t reqs[$];
  frm_t exp_f[$];
  int   exp_ovf[$];

  logic [7:0] got_b[$];
  int         got_bc[$];
  int         got_fd[$];
  logic       got_fdb[$];
  int         got_ovf[$];
  int         got_err[$];

  int cyc, base, b0, fd0, ovf0, err0;
  int uart_dly, drop_at, ucnt;
  int n_checks, n_fail;

  txgen #(.TX_TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .ret_cmd(ret_cmd), .ret_sid(ret_sid), .ret_data(ret_data), .ret_cmd_flg(ret_cmd_flg),
    .tx_data(tx_data), .tx_flag(tx_flag), .tx_done(tx_done),
    .busy(busy), .frame_done(frame_done), .req_ovf(req_ovf), .tx_err(tx_err)
  );

  assign tx_done = uart_done | spur;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // UART model and event recorder.
  initial begin ucnt = 0; uart_done = 1'b0; end
  always @(negedge sys_clk) begin
    uart_done = 1'b0;
    if (!sys_rst) begin
      ucnt = 0;
    end else begin
      if (ucnt > 0) begin
        ucnt = ucnt - 1;
        if (ucnt == 0) uart_done = 1'b1;
      end
      if (tx_flag) begin
        if (got_b.size() != drop_at) ucnt = uart_dly;
        got_b.push_back(tx_data);
        got_bc.push_back(cyc);
      end
      if (frame_done) begin got_fd.push_back(cyc); got_fdb.push_back(busy); end
      if (req_ovf) got_ovf.push_back(cyc);
      if (tx_err) got_err.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_crc(input logic [7:0] sid, input logic [7:0] cmd, input logic [31:0] d);
    logic [7:0]  m [6];
    logic [15:0] c;
    m = '{sid, cmd, d[31:24], d[23:16], d[15:8], d[7:0]};
    c = 16'hFFFF;
    for (int i = 0; i < 6; i++) begin
      c = c ^ {8'h00, m[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [7:0] ref_byte(input frm_t f, input int k);
    logic [7:0]  b [12];
    logic [15:0] c;
    c = ref_crc(f.sid, f.cmd, f.data);
    b = '{8'hAA, 8'h55, 8'h00, 8'h08, f.sid, f.cmd, f.data[31:24], f.data[23:16],
          f.data[15:8], f.data[7:0], c[7:0], c[15:8]};
    return b[k];
  endfunction

  function automatic int frame_len(input int d);
    return 11 * (d + 2) + d + 1;  // first tx_flag to frame_done
  endfunction

  task automatic add_req(input int t, input logic [7:0] sid, input logic [7:0] cmd, input logic [31:0] d);
    req_t r;
    r.t = t; r.sid = sid; r.cmd = cmd; r.data = d;
    reqs.push_back(r);
  endtask

  task automatic push_frame(input int i, input int f0);
    frm_t f;
    f.f0 = f0; f.sid = reqs[i].sid; f.cmd = reqs[i].cmd; f.data = reqs[i].data;
    exp_f.push_back(f);
  endtask

  // Frame schedule from request times: a frame busies the link until its
  // frame_done cycle; one request may wait; a waiting request starts one
  // cycle after frame_done; anything beyond that is dropped.
  task automatic build_model(input int d);
    int cur_end, pidx, flen, t;
    bit pv;
    flen = frame_len(d);
    cur_end = -1000000; pv = 0; pidx = 0;
    exp_f.delete(); exp_ovf.delete();
    foreach (reqs[i]) begin
      t = reqs[i].t;
      if (pv && cur_end - 1 < t) begin
        push_frame(pidx, cur_end + 1); cur_end = cur_end + 1 + flen; pv = 0;
      end
      if (t >= cur_end) begin
        push_frame(i, t + 2); cur_end = t + 2 + flen;
      end else if (t == cur_end - 1) begin
        if (pv) begin push_frame(pidx, cur_end + 1); pidx = i; end
        else push_frame(i, cur_end + 1);
        cur_end = cur_end + 1 + flen;
      end else if (pv) begin
        exp_ovf.push_back(t + 1);
      end else begin
        pv = 1; pidx = i;
      end
    end
    if (pv) push_frame(pidx, cur_end + 1);
  endtask

  task automatic drive_reqs();
    int k, last_t;
    @(negedge sys_clk);
    base = cyc; b0 = got_b.size(); fd0 = got_fd.size();
    ovf0 = got_ovf.size(); err0 = got_err.size();
    k = 0;
    last_t = reqs[reqs.size()-1].t;
    for (int c = 0; c <= last_t; c++) begin
      if (k < reqs.size() && reqs[k].t == c) begin
        ret_cmd_flg = 1'b1; ret_sid = reqs[k].sid; ret_cmd = reqs[k].cmd; ret_data = reqs[k].data;
        k++;
      end else begin
        ret_cmd_flg = 1'b0;
      end
      @(negedge sys_clk);
    end
    ret_cmd_flg = 1'b0;
  endtask

  task automatic run_scn(input string tag, input int d);
    int flen, end_t, nb, efd, nfd, novf;
    logic eb;
    uart_dly = d;
    flen = frame_len(d);
    drive_reqs();
    build_model(d);
    end_t = 0;
    foreach (exp_f[f]) if (exp_f[f].f0 + flen > end_t) end_t = exp_f[f].f0 + flen;
    while (cyc - base < end_t + 8) @(negedge sys_clk);
    nb = got_b.size() - b0; nfd = got_fd.size() - fd0; novf = got_ovf.size() - ovf0;
    check({tag, ".nbytes"}, nb, 12 * exp_f.size());
    check({tag, ".nframes"}, nfd, exp_f.size());
    check({tag, ".novf"}, novf, exp_ovf.size());
    check({tag, ".nerr"}, got_err.size() - err0, 0);
    foreach (exp_f[f]) begin
      for (int k = 0; k < 12; k++) begin
        if (12 * f + k < nb) begin
          check($sformatf("%s.f%0d.byte%0d", tag, f, k), 32'(got_b[b0 + 12*f + k]), 32'(ref_byte(exp_f[f], k)));
          check($sformatf("%s.f%0d.cyc%0d", tag, f, k), got_bc[b0 + 12*f + k] - base, exp_f[f].f0 + k * (d + 2));
        end
      end
      efd = exp_f[f].f0 + flen;
      eb = (f + 1 < exp_f.size()) && (exp_f[f+1].f0 == efd + 1);
      if (f < nfd) begin
        check($sformatf("%s.f%0d.fd_cyc", tag, f), got_fd[fd0 + f] - base, efd);
        check($sformatf("%s.f%0d.fd_busy", tag, f), 32'(got_fdb[fd0 + f]), 32'(eb));
      end
    end
    foreach (exp_ovf[j]) if (j < novf) check($sformatf("%s.ovf%0d", tag, j), got_ovf[ovf0 + j] - base, exp_ovf[j]);
  endtask

  initial begin
    int t, flen, d, n0, fdn0, gap;
    n_checks = 0; n_fail = 0;
    sys_rst = 1'b0; ret_cmd = 8'h00; ret_sid = 8'h00; ret_data = 32'h0; ret_cmd_flg = 1'b0;
    spur = 1'b0; uart_dly = 10; drop_at = -1; base = 0;
    repeat (3) @(negedge sys_clk);
    check("reset_outs", 32'({tx_data, tx_flag, busy, frame_done, req_ovf, tx_err}), 0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("post_reset_outs", 32'({tx_data, tx_flag, busy, frame_done, req_ovf, tx_err}), 0);

    // Basic frame.
    reqs.delete(); add_req(0, 8'h01, 8'h03, 32'h12345678);
    run_scn("single", 10);

    // All-zero payload twice: CRC restarts from 0xFFFF each frame.
    reqs.delete(); add_req(0, 8'h00, 8'h00, 32'h0);
    run_scn("zero_a", 10);
    reqs.delete(); add_req(0, 8'h00, 8'h00, 32'h0);
    run_scn("zero_b", 10);

    // Pending capture and overflow.
    reqs.delete();
    add_req(0, 8'h11, 8'h21, 32'hA1B2C3D4);
    add_req(5, 8'h12, 8'h22, 32'h01020304);
    add_req(6, 8'h13, 8'h23, 32'hFFFFFFFF);
    run_scn("three_req", 10);

    // Request in the last-tx_done cycle: promotion plus capture.
    flen = frame_len(10);
    reqs.delete();
    add_req(0, 8'h31, 8'h41, 32'h0BADF00D);
    add_req(5, 8'h32, 8'h42, 32'hDEADBEEF);
    add_req(flen + 1, 8'h33, 8'h43, 32'hCAFEBABE);
    run_scn("promote_cap", 10);

    // Request in the last-tx_done cycle with pending empty.
    reqs.delete();
    add_req(0, 8'h51, 8'h61, 32'h55AA55AA);
    add_req(flen + 1, 8'h52, 8'h62, 32'h13579BDF);
    run_scn("direct_chain", 10);

    // Timeout on byte 3 with a request parked in pending.
    reqs.delete();
    add_req(0, 8'h71, 8'h72, 32'h11223344);
    add_req(20, 8'h73, 8'h74, 32'h55667788);
    uart_dly = 10;
    drop_at = got_b.size() + 3;
    drive_reqs();
    while (cyc - base < 300) @(negedge sys_clk);
    check("tmo.nerr", got_err.size() - err0, 1);
    if (got_err.size() > err0) check("tmo.err_cyc", got_err[err0] - base, 2 + 3 * 12 + TO);
    check("tmo.nbytes", got_b.size() - b0, 4);
    check("tmo.nframes", got_fd.size() - fd0, 0);
    check("tmo.busy", 32'(busy), 0);
    drop_at = -1;
    reqs.delete(); add_req(0, 8'h75, 8'h76, 32'h99AABBCC);
    run_scn("after_tmo", 10);

    // Reset in the middle of byte 7.
    reqs.delete(); add_req(0, 8'h81, 8'h82, 32'h87654321);
    uart_dly = 10;
    drive_reqs();
    for (int i = 0; i < 500 && (got_b.size() - b0) < 8; i++) @(negedge sys_clk);
    check("rst.reach_b7", got_b.size() - b0, 8);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    check("rst.async_outs", 32'({tx_data, tx_flag, busy, frame_done, req_ovf, tx_err}), 0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (40) @(negedge sys_clk);
    check("rst.no_more_bytes", got_b.size() - b0, 8);
    check("rst.busy", 32'(busy), 0);
    reqs.delete(); add_req(0, 8'h83, 8'h84, 32'h0F0F0F0F);
    run_scn("after_rst", 10);

    // Stray tx_done while idle.
    @(negedge sys_clk);
    n0 = got_b.size(); fdn0 = got_fd.size();
    for (int i = 0; i < 20; i++) begin
      spur = ($urandom_range(0, 1) == 1);
      @(negedge sys_clk);
    end
    spur = 1'b1; @(negedge sys_clk); spur = 1'b0;
    repeat (5) @(negedge sys_clk);
    check("spur.nbytes", got_b.size() - n0, 0);
    check("spur.nframes", got_fd.size() - fdn0, 0);
    check("spur.busy", 32'(busy), 0);

    // tx_done on the timeout terminal count.
    reqs.delete(); add_req(0, 8'h91, 8'h92, 32'h24681357);
    run_scn("tmo_edge", TO - 1);

    // Randomized request streams.
    for (int r = 0; r < 3; r++) begin
      d = int'($urandom_range(1, 20));
      flen = frame_len(d);
      reqs.delete();
      t = 0;
      for (int i = 0; i < 6; i++) begin
        add_req(t, 8'($urandom), 8'($urandom), 32'($urandom));
        gap = int'($urandom_range(1, 32'(flen + flen / 2)));
        t = t + gap;
      end
      run_scn($sformatf("rand%0d", r), d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
